// File: rtl/adder_bist.sv
// Built-in self-test controller for a 1-bit full adder with propagate/generate outputs.
// Sweeps {cin,a,b} = 0..7 for PASSES sweeps, counts mismatches and latches the first failing vector.
module adder_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    output logic       dut_cin_o,
    output logic       dut_a_o,
    output logic       dut_b_o,
    input  logic       dut_s_i,
    input  logic       dut_cout_i,
    input  logic       dut_p_i,
    input  logic       dut_g_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [7:0] err_count_o,
    output logic       first_err_valid_o,
    output logic [6:0] first_err_vec_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    // Golden response {s,cout,p,g} for a stimulus vector {cin,a,b}
    function automatic logic [3:0] golden_fn(input logic [2:0] vec);
        logic cin;
        logic a;
        logic b;
        cin = vec[2];
        a   = vec[1];
        b   = vec[0];
        return {a ^ b ^ cin, (a & b) | (cin & (a ^ b)), a ^ b, a & b};
    endfunction

    state_t     state_q;
    logic [2:0] vec_q;
    logic [2:0] stim_q;
    logic [3:0] settle_q;
    logic [7:0] pass_cnt_q;
    logic [7:0] err_count_q;
    logic [7:0] err_count_d;
    logic       first_err_valid_q;
    logic [6:0] first_err_vec_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] resp_s;
    logic       mismatch_s;

    // Response compare against the driven vector; the case-equality makes X/Z a mismatch
    always_comb begin
        resp_s      = {dut_s_i, dut_cout_i, dut_p_i, dut_g_i};
        mismatch_s  = (resp_s === golden_fn(stim_q)) ? 1'b0 : 1'b1;
        err_count_d = err_count_q;
        if (mismatch_s && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Sequencer FSM with registered stimulus, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            vec_q             <= 3'd0;
            stim_q            <= 3'd0;
            settle_q          <= 4'd0;
            pass_cnt_q        <= 8'd0;
            err_count_q       <= 8'd0;
            first_err_valid_q <= 1'b0;
            first_err_vec_q   <= 7'd0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q           <= ST_DRIVE;
                        vec_q             <= 3'd0;
                        stim_q            <= 3'd0;
                        settle_q          <= 4'd0;
                        pass_cnt_q        <= 8'd0;
                        err_count_q       <= 8'd0;
                        first_err_valid_q <= 1'b0;
                        first_err_vec_q   <= 7'd0;
                        busy_q            <= 1'b1;
                        done_q            <= 1'b0;
                    end else begin
                        stim_q <= 3'd0;
                        busy_q <= 1'b0;
                        done_q <= (state_q == ST_DONE);
                    end
                end
                ST_DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= 4'd0;
                        state_q  <= ST_CHECK;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                ST_CHECK: begin
                    err_count_q <= err_count_d;
                    if (mismatch_s && !first_err_valid_q) begin
                        first_err_valid_q <= 1'b1;
                        first_err_vec_q   <= {stim_q, resp_s};
                    end
                    if (vec_q != 3'd7) begin
                        vec_q   <= vec_q + 3'd1;
                        stim_q  <= vec_q + 3'd1;
                        state_q <= ST_DRIVE;
                    end else if (pass_cnt_q < PASS_LAST) begin
                        vec_q      <= 3'd0;
                        stim_q     <= 3'd0;
                        pass_cnt_q <= pass_cnt_q + 8'd1;
                        state_q    <= ST_DRIVE;
                    end else begin
                        stim_q  <= 3'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    stim_q  <= 3'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_cin_o         = stim_q[2];
    assign dut_a_o           = stim_q[1];
    assign dut_b_o           = stim_q[0];
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = done_q & (err_count_q == 8'd0);
    assign err_count_o       = err_count_q;
    assign first_err_valid_o = first_err_valid_q;
    assign first_err_vec_o   = first_err_vec_q;

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: two instances (default and SETTLE=3/PASSES=40) each
// beside an adder model whose responses are corrupted by a per-vector XOR fault table.
module tb_adder_bist;

    localparam int SET_B  = 3;
    localparam int PASS_B = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b;
    logic cin_a, av_a, bv_a, s_a, co_a, p_a, g_a, busy_a, done_a, pass_a, fv_a;
    logic cin_b, av_b, bv_b, s_b, co_b, p_b, g_b, busy_b, done_b, pass_b, fv_b;
    logic [7:0] err_a, err_b;
    logic [6:0] fvec_a, fvec_b;
    logic [7:0][3:0] mask_a, mask_b;

    int n_checks = 0;
    int n_fail   = 0;

    adder_bist u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a),
        .dut_cin_o(cin_a), .dut_a_o(av_a), .dut_b_o(bv_a),
        .dut_s_i(s_a), .dut_cout_i(co_a), .dut_p_i(p_a), .dut_g_i(g_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_count_o(err_a),
        .first_err_valid_o(fv_a), .first_err_vec_o(fvec_a)
    );

    adder_bist #(.SETTLE_CYCLES(SET_B), .PASSES(PASS_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b),
        .dut_cin_o(cin_b), .dut_a_o(av_b), .dut_b_o(bv_b),
        .dut_s_i(s_b), .dut_cout_i(co_b), .dut_p_i(p_b), .dut_g_i(g_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_count_o(err_b),
        .first_err_valid_o(fv_b), .first_err_vec_o(fvec_b)
    );

    // Reference adder from arithmetic: {s,cout,p,g}
    function automatic logic [3:0] ref_resp(input logic [2:0] v);
        int cin = int'(v[2]);
        int a   = int'(v[1]);
        int b   = int'(v[0]);
        int sum = a + b + cin;
        return {1'(sum % 2), 1'(sum / 2), 1'(a != b), 1'(a + b == 2)};
    endfunction

    always_comb {s_a, co_a, p_a, g_a} = ref_resp({cin_a, av_a, bv_a}) ^ mask_a[{cin_a, av_a, bv_a}];
    always_comb {s_b, co_b, p_b, g_b} = ref_resp({cin_b, av_b, bv_b}) ^ mask_b[{cin_b, av_b, bv_b}];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected results: every faulty vector fails once per sweep; first failure is the lowest faulty vector
    task automatic model(input logic [7:0][3:0] m, input int passes,
                         output int e, output logic fv, output logic [6:0] vec);
        int bad = 0;
        fv  = 1'b0;
        vec = 7'd0;
        for (int v = 0; v < 8; v++) begin
            if (m[v] != 4'd0) begin
                bad++;
                if (!fv) begin
                    fv  = 1'b1;
                    vec = {3'(v), ref_resp(3'(v)) ^ m[v]};
                end
            end
        end
        e = bad * passes;
        if (e > 255) e = 255;
    endtask

    task automatic run(input bit sel, input string tag, input logic [7:0][3:0] m,
                       input int passes, input int settle);
        int cyc = 0;
        int bad_stim = 0;
        int overlap = 0;
        int exp_e;
        logic exp_fv;
        logic [6:0] exp_vec;
        logic [2:0] stim;
        if (sel) mask_b = m; else mask_a = m;
        @(posedge clk); #1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        while ((sel ? busy_b : busy_a) && cyc < 5000) begin
            stim = sel ? {cin_b, av_b, bv_b} : {cin_a, av_a, bv_a};
            if (stim != 3'((cyc / (settle + 1)) % 8)) bad_stim++;
            if (sel ? done_b : done_a) overlap++;
            cyc++;
            @(posedge clk); #1;
        end
        model(m, passes, exp_e, exp_fv, exp_vec);
        check({tag, "_cycles"}, 32'(cyc), 32'(passes * 8 * (settle + 1)));
        check({tag, "_stim_order"}, 32'(bad_stim), 32'd0);
        check({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_done"}, 32'(sel ? done_b : done_a), 32'd1);
        check({tag, "_pass"}, 32'(sel ? pass_b : pass_a), 32'(exp_e == 0));
        check({tag, "_err_count"}, 32'(sel ? err_b : err_a), 32'(exp_e));
        check({tag, "_first_valid"}, 32'(sel ? fv_b : fv_a), 32'(exp_fv));
        check({tag, "_first_vec"}, 32'(sel ? fvec_b : fvec_a), 32'(exp_vec));
        check({tag, "_stim_idle"}, 32'(sel ? {cin_b, av_b, bv_b} : {cin_a, av_a, bv_a}), 32'd0);
    endtask

    initial begin
        logic [7:0][3:0] m;
        logic [3:0] r;
        int guard;
        int exp_e;
        logic exp_fv;
        logic [6:0] exp_vec;

        mask_a  = '0;
        mask_b  = '0;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_a", 32'({busy_a, done_a, pass_a, fv_a, cin_a, av_a, bv_a, err_a, fvec_a}), 32'd0);
        check("reset_outputs_b", 32'({busy_b, done_b, pass_b, fv_b, cin_b, av_b, bv_b, err_b, fvec_b}), 32'd0);
        rst_n = 1'b1;

        m = '0;
        run(1'b0, "good", m, 1, 1);

        for (int v = 0; v < 8; v++) begin
            r    = ref_resp(3'(v));
            m[v] = {3'b000, r[0]};
        end
        run(1'b0, "g_stuck0", m, 1, 1);

        for (int i = 0; i < 4; i++) begin
            for (int v = 0; v < 8; v++) begin
                m[v] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            end
            run(1'b0, "random", m, 1, 1);
        end

        for (int v = 0; v < 8; v++) m[v] = 4'b0100;
        run(1'b1, "cout_inv_p40_s3", m, PASS_B, SET_B);

        // Asynchronous reset while vector 5 is being driven
        m    = '0;
        m[0] = 4'b1000;
        mask_a = m;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        guard = 0;
        while ({cin_a, av_a, bv_a} != 3'd5 && guard < 200) begin
            guard++;
            @(posedge clk); #1;
        end
        check("rst_reach_vec5", 32'({cin_a, av_a, bv_a}), 32'd5);
        check("rst_err_before", 32'(err_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 32'({busy_a, done_a, pass_a, fv_a, cin_a, av_a, bv_a, err_a, fvec_a}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        guard = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done_a || busy_a) guard++;
        end
        check("rst_no_done_pulse", 32'(guard), 32'd0);
        m = '0;
        run(1'b0, "post_rst", m, 1, 1);

        // start held high: ignored while busy, restarts from DONE
        m    = '0;
        m[3] = 4'b0001;
        mask_a = m;
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        guard = 0;
        while (busy_a && guard < 200) begin
            guard++;
            @(posedge clk); #1;
        end
        model(m, 1, exp_e, exp_fv, exp_vec);
        check("hold_cycles", 32'(guard), 32'd16);
        check("hold_done", 32'(done_a), 32'd1);
        check("hold_err", 32'(err_a), 32'(exp_e));
        check("hold_first_vec", 32'(fvec_a), 32'(exp_vec));
        @(posedge clk); #1;
        check("hold_restart", 32'({done_a, busy_a, fv_a, err_a}), 32'({1'b0, 1'b1, 1'b0, 8'd0}));
        start_a = 1'b0;
        guard = 0;
        while (!done_a && guard < 200) begin
            guard++;
            @(posedge clk); #1;
        end
        check("hold_second_done", 32'({done_a, err_a}), 32'({1'b1, 8'(exp_e)}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
